// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default constants for the memory-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   owner_e     : which requester owns the current transaction
//   *_DEF       : default widths / starvation limit used as parameter defaults
//   STREAK_W    : width of the data-streak counter (holds STARVE_MAX up to 15)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STREAK_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// -----------------------------------------------------------------------------
// mem_arb_prio
// Priority selection between the fetch and data requesters, with a starvation
// guard for fetch.
//   clk, rst   : clock, synchronous active-high reset
//   if_req     : fetch request pending
//   d_req      : data request pending
//   gnt_stb    : a grant is being given this cycle (to owner_sel)
//   owner_sel  : requester that wins if a grant is given this cycle
//   streak     : consecutive data grants given while fetch was waiting
// Data normally wins a conflict; once the streak reaches STARVE_MAX, fetch
// wins the next conflict and the streak restarts.
// -----------------------------------------------------------------------------
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic                d_req,
  input  logic                gnt_stb,
  output owner_e              owner_sel,
  output logic [STREAK_W-1:0] streak
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                fetch_starved;

  always_comb begin
    fetch_starved = (streak_q == STREAK_MAX);
    owner_sel     = OWN_IF;
    // Data wins unless fetch is also waiting and has been passed over too often.
    if (d_req && !(if_req && fetch_starved)) begin
      owner_sel = OWN_D;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req) begin
      // Fetch is not waiting, so there is no starvation to track.
      streak_d = '0;
    end else if (gnt_stb) begin
      if (owner_sel == OWN_IF) begin
        streak_d = '0;
      end else if (!fetch_starved) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign streak = streak_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between an instruction-fetch port and a data
// port, with at most one transaction outstanding.
//   clk, rst          : clock, synchronous active-high reset
//   if_req/if_addr    : fetch request and address
//   if_gnt            : fetch request accepted (one-cycle pulse in IDLE)
//   if_rvalid/if_rdata: fetch response (rdata is 0 when rvalid is 0)
//   if_flush          : discard the in-flight fetch response
//   d_req/d_we/d_addr/d_wdata/d_be : data request and payload
//   d_gnt             : data request accepted
//   d_rvalid/d_rdata  : data response (read data or write ack)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : memory request (held until ready)
//   mem_ready         : memory accepts the request
//   mem_rvalid/mem_rdata : memory response, one per accepted request
// Optional build macro MEM_ARB_PERF_EN adds three 32-bit wrapping counters:
//   perf_if_grants, perf_d_grants, perf_conflicts (IDLE cycles with both
//   requesters pending).
// Response data is forwarded combinationally from mem_rdata, so the minimum
// grant-to-response latency is 2 cycles and the peak rate is one transaction
// every 3 cycles.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                if_flush,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_grants,
  output logic [31:0]         perf_d_grants,
  output logic [31:0]         perf_conflicts
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                kill_q, kill_d;

  logic                any_req;
  logic                grant;
  logic                flush_hit;
  owner_e              owner_sel;
  logic [STREAK_W-1:0] streak;

  assign any_req   = if_req | d_req;
  // A grant is only ever given from IDLE, so it can never coincide with a response.
  assign grant     = !rst && (state_q == IDLE) && any_req;
  assign flush_hit = if_flush && (owner_q == OWN_IF);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .d_req     (d_req),
    .gnt_stb   (grant),
    .owner_sel (owner_sel),
    .streak    (streak)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      kill_q  <= kill_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and latch logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (any_req) begin
          state_d = ISSUE;
          owner_d = owner_sel;
          if (owner_sel == OWN_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            be_d    = d_be;
          end else begin
            // Fetch is always a full-word read.
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            be_d    = '1;
          end
        end
      end
      ISSUE: begin
        kill_d = kill_q | flush_hit;
        if (mem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end else begin
          kill_d = kill_q | flush_hit;
        end
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic; everything is held at 0 while rst is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            if_gnt = (owner_sel == OWN_IF);
            d_gnt  = (owner_sel == OWN_D);
          end
        end
        ISSUE: begin
          mem_req   = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          mem_be    = be_q;
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (owner_q == OWN_D) begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end else if (!kill_q && !if_flush) begin
              // A flush in the response cycle itself also drops the response.
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The streak can never pass the starvation limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (streak <= STREAK_MAX);
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_grants_q, perf_if_grants_d;
  logic [31:0] perf_d_grants_q, perf_d_grants_d;
  logic [31:0] perf_conflicts_q, perf_conflicts_d;

  always_comb begin
    perf_if_grants_d = perf_if_grants_q + 32'(grant && (owner_sel == OWN_IF));
    perf_d_grants_d  = perf_d_grants_q + 32'(grant && (owner_sel == OWN_D));
    perf_conflicts_d = perf_conflicts_q + 32'(grant && if_req && d_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_grants_q <= '0;
      perf_d_grants_q  <= '0;
      perf_conflicts_q <= '0;
    end else begin
      perf_if_grants_q <= perf_if_grants_d;
      perf_d_grants_q  <= perf_d_grants_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_if_grants = perf_if_grants_q;
  assign perf_d_grants  = perf_d_grants_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench: stimulus pushes the expected transaction (owner, memory
// fields, response data, grant-to-response latency) when it raises a request;
// a monitor pops it on the grant, checks the memory request while it is held,
// and checks the response. A small memory responder answers with
// mem_val(addr) after an optional stall / response delay.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          lat;
    bit          killed;
    bit          abandon;
  } exp_t;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid, if_flush;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_flush(if_flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // memory responder controls
  bit   auto_mem = 1;
  int   stall_cnt = 0;
  int   rsp_delay = 0;

  // monitor state
  bit   mon_busy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h0050_0193;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 160'({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                    mem_req, mem_we, mem_addr, mem_wdata, mem_be}), 160'd0);
  endtask

  // Raise one request (called just after a negedge), wait for its grant,
  // then drop it and scramble the payload on the following negedge.
  task automatic issue(input bit is_d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int lat, input bit killed, input bit abandon);
    exp_t e;
    bit   got;
    e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
    e.rdata = mem_val(addr); e.lat = lat; e.killed = killed; e.abandon = abandon;
    exp_q.push_back(e);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (is_d ? d_gnt : if_gnt) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("gnt_within_budget", 160'(got), 160'd1);
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b0; d_we = 1'b1; d_addr = 32'hBAD0_0004; d_wdata = 32'h5A5A_5A5A; d_be = 4'h0;
    end else begin
      if_req = 1'b0; if_addr = 32'hBAD0_0000;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || mon_busy); i++) @(negedge clk);
  endtask

  // Memory responder: decides mem_ready / mem_rvalid for the next rising edge.
  initial begin : responder
    bit          rsp_pend;
    int          dly_cnt;
    logic [31:0] rsp_val;
    rsp_pend = 0; dly_cnt = 0; rsp_val = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_mem) begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rsp_pend) begin
          if (dly_cnt > 0) dly_cnt--;
          else begin
            mem_rvalid = 1'b1;
            mem_rdata  = rsp_val;
            rsp_pend   = 0;
          end
        end
        mem_ready = 1'b0;
        if (mem_req === 1'b1) begin
          if (stall_cnt > 0) stall_cnt--;
          else begin
            mem_ready = 1'b1;
            rsp_pend  = 1;
            dly_cnt   = rsp_delay;
            rsp_val   = mem_val(mem_addr);
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    exp_t cur;
    int   lat;
    int   txn;
    bit   seen_req;
    bit   rsp;
    bit   exp_if, exp_dv;
    lat = 0; txn = 0; seen_req = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (mon_busy) begin
          chk("abandon_on_rst", 160'(cur.abandon), 160'd1);
          $display("txn %0d: %s addr=0x%08h abandoned by reset", txn++, cur.is_d ? "D " : "IF", cur.addr);
          mon_busy = 0;
        end
      end else begin
        if (mon_busy) lat++;
        if (if_gnt || d_gnt) begin
          chk("gnt_only_when_free", 160'(mon_busy), 160'd0);
          chk("gnt_expected", 160'(exp_q.size() > 0), 160'd1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("gnt_owner", 160'({if_gnt, d_gnt}), cur.is_d ? 160'd1 : 160'd2);
            mon_busy = 1; lat = 0; seen_req = 0;
          end
        end
        if (mon_busy && lat == 1) chk("req_after_gnt", 160'(mem_req), 160'd1);
        if (mem_req) begin
          seen_req = 1;
          if (mon_busy)
            chk("mem_fields",
                cur.is_d ? 160'({mem_we, mem_addr, mem_wdata, mem_be}) : 160'({mem_we, mem_addr}),
                cur.is_d ? 160'({cur.we, cur.addr, cur.wdata, cur.be}) : 160'({1'b0, cur.addr}));
          else
            chk("req_without_gnt", 160'(mem_req), 160'd0);
        end
        rsp = if_rvalid || d_rvalid || (mon_busy && seen_req && !mem_req && mem_rvalid);
        if (rsp) begin
          if (!mon_busy) begin
            chk("rvalid_unexpected", 160'({if_rvalid, d_rvalid}), 160'd0);
          end else begin
            exp_if = !cur.is_d && !cur.killed;
            exp_dv = cur.is_d;
            chk("rvalid_port", 160'({if_rvalid, d_rvalid}), 160'({exp_if, exp_dv}));
            chk("rdata", 160'({if_rdata, d_rdata}),
                160'({exp_if ? cur.rdata : 32'd0, exp_dv ? cur.rdata : 32'd0}));
            chk("latency", 160'(lat), 160'(cur.lat));
            $display("txn %0d: %s %s addr=0x%08h rdata=0x%08h lat=%0d%s", txn++,
                     cur.is_d ? "D " : "IF", cur.we ? "WR" : "RD", cur.addr,
                     cur.is_d ? d_rdata : if_rdata, lat, cur.killed ? " (flushed)" : "");
            mon_busy = 0;
          end
        end else begin
          chk("rdata_zero_when_idle", 160'({if_rdata, d_rdata}), 160'd0);
        end
      end
    end
  end

  // Stimulus
  initial begin : stimulus
    int n;
    rst = 1'b1; if_flush = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0; d_be = 4'hF;
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset_outputs_zero");
    @(negedge clk);
    #1 chk_all_zero("reset_outputs_zero_2");
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single fetch: gnt at 0, mem_req at 1, rvalid 0x00500093 at 2
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF, 2, 0, 0);
    drain();
    // data read
    issue(1, 1'b0, 32'h2000, 32'h0, 4'hF, 2, 0, 0);
    drain();
    // data write with 3 cycles of backpressure; fetch waits behind it
    stall_cnt = 3;
    issue(1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 5, 0, 0);
    issue(0, 1'b0, 32'h104, 32'h0, 4'hF, 2, 0, 0);
    drain();
    // partial-byte write
    issue(1, 1'b1, 32'h2004, 32'h1234_5678, 4'h3, 2, 0, 0);
    drain();

    // flush in first WAIT cycle; response arrives two cycles later
    rsp_delay = 2;
    issue(0, 1'b0, 32'h200, 32'h0, 4'hF, 4, 1, 0);
    @(negedge clk); if_flush = 1'b1;
    @(negedge clk); if_flush = 1'b0;
    drain();
    rsp_delay = 0;
    issue(1, 1'b0, 32'h2010, 32'h0, 4'hF, 2, 0, 0);
    drain();
    // flush in the response cycle itself
    issue(0, 1'b0, 32'h204, 32'h0, 4'hF, 2, 1, 0);
    @(negedge clk); if_flush = 1'b1;
    @(negedge clk); if_flush = 1'b0;
    drain();
    // flush during a data transaction (ISSUE, WAIT and the following IDLE)
    issue(1, 1'b0, 32'h2020, 32'h0, 4'hF, 2, 0, 0);
    if_flush = 1'b1;
    repeat (2) @(negedge clk);
    if_flush = 1'b0;
    issue(0, 1'b0, 32'h208, 32'h0, 4'hF, 2, 0, 0);
    drain();

    // reset in WAIT, then a late mem_rvalid
    @(negedge clk); auto_mem = 0;
    @(negedge clk);
    issue(0, 1'b0, 32'h300, 32'h0, 4'hF, 0, 0, 1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; rst = 1'b1;
    #1 chk_all_zero("rst_mid_wait_zero");
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1 chk_all_zero("late_rvalid_ignored");
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0; auto_mem = 1;
    issue(1, 1'b0, 32'h2008, 32'h0, 4'hF, 2, 0, 0);
    drain();

    // conflict: both held, order D,D,D,D,IF,D,D,D,D,IF
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 10; g++) begin
      exp_t e;
      e.is_d = !(g == 4 || g == 9);
      e.we = 1'b0; e.addr = e.is_d ? 32'h2000 : 32'h100;
      e.wdata = 32'h1111_1111; e.be = 4'hF; e.rdata = mem_val(e.addr);
      e.lat = 2; e.killed = 0; e.abandon = 0;
      exp_q.push_back(e);
    end
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'h1111_1111; d_be = 4'hF;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (if_gnt || d_gnt) n++;
      if (n == 10) break;
      @(negedge clk);
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    chk("conflict_grant_count", 160'(n), 160'd10);
    drain();
`ifdef MEM_ARB_PERF_EN
    chk("perf_d_grants", 160'(perf_d_grants), 160'd8);
    chk("perf_if_grants", 160'(perf_if_grants), 160'd2);
    chk("perf_conflicts", 160'(perf_conflicts), 160'd10);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 160'(exp_q.size()), 160'd0);
    chk("monitor_idle", 160'(mon_busy), 160'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
